// File: rtl/key_mat_add.sv
// Lane-wise modular add/subtract of two NBAR x NBAR matrices streamed from
// synchronous RAMs; one 64-bit result word is written per cycle.
module key_mat_add #(
  parameter int NBAR      = 8,
  parameter int T         = 4,
  parameter int WORD_SIZE = 16 * T,
  parameter int N_WORDS   = NBAR * NBAR / T,
  localparam int ADDR_W   = $clog2(N_WORDS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2:0]           i_sec_level,
  input  logic                 i_sub,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  input  logic [WORD_SIZE-1:0] i_k_mat,
  input  logic [WORD_SIZE-1:0] i_v_mat,
  output logic [WORD_SIZE-1:0] o_c_mat,
  output logic [ADDR_W-1:0]    o_c_mat_addr,
  output logic                 o_c_mat_wen,
  output logic                 o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      rd_addr_reg;
  logic                   q15_reg;
  logic                   sub_reg;
  logic                   s1_valid_reg;
  logic [ADDR_W-1:0]      s1_addr_reg;
  logic [WORD_SIZE-1:0]   c_mat_reg;
  logic [ADDR_W-1:0]      c_addr_reg;
  logic                   c_wen_reg;
  logic [WORD_SIZE-1:0]   lane_result;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (rd_addr_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (c_wen_reg && (c_addr_reg == LAST_ADDR)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_rd_en = 1'b0;
    o_done  = 1'b0;
    case (state_reg)
      RUN:     o_rd_en = 1'b1;
      DONE:    o_done  = 1'b1;
      default: ;
    endcase
  end

  // Read address generation and mode latch; mode only changes on an accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_addr_reg <= '0;
      q15_reg     <= 1'b0;
      sub_reg     <= 1'b0;
    end else if (state_reg == IDLE && i_start) begin
      rd_addr_reg <= '0;
      q15_reg     <= (i_sec_level == 3'd1);
      sub_reg     <= i_sub;
    end else if (state_reg == RUN) begin
      rd_addr_reg <= rd_addr_reg + 1'b1;
    end
  end

  // Separate 16-bit arithmetic per lane keeps carries/borrows inside each lane
  for (genvar gi = 0; gi < T; gi++) begin : g_lane
    logic [15:0] v_lane;
    logic [15:0] k_lane;
    logic [15:0] sum_lane;
    assign v_lane   = i_v_mat[16*gi +: 16];
    assign k_lane   = i_k_mat[16*gi +: 16];
    assign sum_lane = sub_reg ? (v_lane - k_lane) : (v_lane + k_lane);
    assign lane_result[16*gi +: 16] = {sum_lane[15] & ~q15_reg, sum_lane[14:0]};
  end

  // Stage 1 tracks RAM read latency; stage 2 registers the result write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      c_mat_reg    <= '0;
      c_addr_reg   <= '0;
      c_wen_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= o_rd_en;
      s1_addr_reg  <= rd_addr_reg;
      c_wen_reg    <= s1_valid_reg;
      if (s1_valid_reg) begin
        c_mat_reg  <= lane_result;
        c_addr_reg <= s1_addr_reg;
      end
    end
  end

  assign o_rd_addr    = rd_addr_reg;
  assign o_c_mat      = c_mat_reg;
  assign o_c_mat_addr = c_addr_reg;
  assign o_c_mat_wen  = c_wen_reg;

endmodule

// File: tb/tb_key_mat_add.sv
// Directed bench for key_mat_add: source RAMs modelled with 1-cycle read
// latency, every output cycle checked against hand-derived expectations.
module tb_key_mat_add;

  localparam int W = 64;
  localparam int N = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    sec_level;
  logic          sub;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [W-1:0]  k_q;
  logic [W-1:0]  v_q;
  logic [W-1:0]  c_mat;
  logic [3:0]    c_addr;
  logic          c_wen;
  logic          done;

  logic [W-1:0]  k_mem   [N];
  logic [W-1:0]  v_mem   [N];
  logic [W-1:0]  exp_mem [N];

  int tests;
  int fails;

  key_mat_add dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_sec_level  (sec_level),
    .i_sub        (sub),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_k_mat      (k_q),
    .i_v_mat      (v_q),
    .o_c_mat      (c_mat),
    .o_c_mat_addr (c_addr),
    .o_c_mat_wen  (c_wen),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous source RAMs with one cycle of read latency
  always @(posedge clk) begin
    if (rd_en) begin
      k_q <= k_mem[rd_addr];
      v_q <= v_mem[rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] v, input logic [W-1:0] k, input logic [W-1:0] e);
    for (int a = 0; a < N; a++) begin
      v_mem[a]   = v;
      k_mem[a]   = k;
      exp_mem[a] = e;
    end
  endtask

  // One pass from start; restart_at / reset_at give the edge index at which a
  // second start or a reset is sampled (-1 disables).
  task automatic run_pass(input logic [2:0] lvl, input logic op_sub,
                          input int restart_at, input int reset_at);
    int wen_cnt;
    int done_cnt;
    wen_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    sec_level = lvl;
    sub       = op_sub;
    start     = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start = 1'b0;
      if (reset_at >= 0 && c == reset_at) begin
        chk("rst_rd_en", W'(rd_en), '0);
        chk("rst_rd_addr", W'(rd_addr), '0);
        chk("rst_c_mat", c_mat, '0);
        chk("rst_c_addr", W'(c_addr), '0);
        chk("rst_c_wen", W'(c_wen), '0);
        chk("rst_done", W'(done), '0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          chk("post_rst_wen", W'(c_wen), '0);
          chk("post_rst_done", W'(done), '0);
        end
        $display("[TB] pass lvl=%0d sub=%0d reset at edge %0d", lvl, op_sub, reset_at);
        return;
      end
      chk("rd_en", W'(rd_en), W'(c <= 15));
      if (c <= 15) chk("rd_addr", W'(rd_addr), W'(c));
      chk("c_wen", W'(c_wen), W'(c >= 2 && c <= 17));
      if (c >= 2 && c <= 17) begin
        chk("c_addr", W'(c_addr), W'(c - 2));
        chk("c_mat", c_mat, exp_mem[c-2]);
      end
      chk("done", W'(done), W'(c == 18));
      if (c_wen) wen_cnt++;
      if (done) done_cnt++;
      if (restart_at >= 0 && c == restart_at - 1) begin
        start     = 1'b1;
        sec_level = (lvl == 3'd1) ? 3'd5 : 3'd1;
        sub       = ~op_sub;
      end
      if (restart_at >= 0 && c == restart_at) start = 1'b0;
      if (reset_at >= 0 && c == reset_at - 1) rst = 1'b1;
    end
    chk("wen_count", W'(wen_cnt), W'(16));
    chk("done_count", W'(done_cnt), W'(1));
    $display("[TB] pass lvl=%0d sub=%0d writes=%0d done=%0d", lvl, op_sub, wen_cnt, done_cnt);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    sec_level = 3'd1;
    sub       = 1'b0;
    k_q       = '0;
    v_q       = '0;
    fill('0, '0, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_en", W'(rd_en), '0);
    chk("reset_rd_addr", W'(rd_addr), '0);
    chk("reset_c_mat", c_mat, '0);
    chk("reset_c_addr", W'(c_addr), '0);
    chk("reset_c_wen", W'(c_wen), '0);
    chk("reset_done", W'(done), '0);
    $display("[TB] reset state checked");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // q=2^15: 0x7FFF+1 wraps to 0 once bit 15 is cleared
    fill({4{16'h7FFF}}, {4{16'h0001}}, 64'h0);
    run_pass(3'd1, 1'b0, -1, -1);

    // q=2^16: lane 0 overflow must not carry into lane 1
    fill(64'h0000_0000_1234_FFFF, 64'h0000_0000_0100_0002, 64'h0000_0000_1334_0001);
    run_pass(3'd3, 1'b0, -1, -1);

    // Subtraction borrow, both moduli
    fill(64'h0, {4{16'h0001}}, {4{16'h7FFF}});
    run_pass(3'd1, 1'b1, -1, -1);
    fill(64'h0, {4{16'h0001}}, {4{16'hFFFF}});
    run_pass(3'd5, 1'b1, -1, -1);

    // Address-dependent data confirms word ordering
    for (int a = 0; a < N; a++) begin
      v_mem[a]   = {4{16'h1000 + 16'(a)}};
      k_mem[a]   = {4{16'h0100}};
      exp_mem[a] = {4{16'h1100 + 16'(a)}};
    end
    run_pass(3'd3, 1'b0, -1, -1);

    // Second start (with different mode inputs) at edge 5 is ignored
    fill({4{16'h7FFF}}, {4{16'h0001}}, 64'h0);
    run_pass(3'd1, 1'b0, 5, -1);

    // Reset sampled at edge 8 aborts the pass; the next pass is clean
    fill(64'h0, {4{16'h0001}}, {4{16'hFFFF}});
    run_pass(3'd5, 1'b1, -1, 8);
    run_pass(3'd5, 1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_mat_add.md
# key_mat_add

Post-encode matrix combiner for FrodoKEM. It reads the n̄×n̄ encoded-key matrix written by `encode` and the matching S'B+E'' (or B'S) matrix word by word from two synchronous RAMs. It adds or subtracts them lane-wise mod q and streams the result into the C2 (or M) RAM. It sits between `encode` and the ciphertext packer in encapsulation, and ahead of `decode` in decapsulation.

## Interface

Parameters:
- `NBAR`, 8: matrix dimension; the matrix holds NBAR*NBAR coefficients.
- `T`, 4: 16-bit coefficients per memory word.
- `WORD_SIZE`, 64: word width, equal to 16*T.
- `N_WORDS`, 16: words per matrix, equal to NBAR*NBAR/T.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `i_sec_level`  in  3  security level; 1 selects q=2^15, any other value selects q=2^16.
- `i_sub`  in  1  0 computes V+K, 1 computes V−K; latched at start.
- `o_rd_en`  out  1  read enable, shared by both source RAMs.
- `o_rd_addr`  out  clog2(N_WORDS)  word address, shared by both source RAMs.
- `i_k_mat`  in  WORD_SIZE  encoded-key word; valid the cycle after the address is issued.
- `i_v_mat`  in  WORD_SIZE  V-matrix word; same timing as `i_k_mat`.
- `o_c_mat`  out  WORD_SIZE  result word.
- `o_c_mat_addr`  out  clog2(N_WORDS)  result address.
- `o_c_mat_wen`  out  1  result write enable.
- `o_done`  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `i_start`=1. At that edge the block latches `i_sec_level` and `i_sub`, sets `o_rd_addr`=0 and sets `o_rd_en`=1.
- RUN increments `o_rd_addr` every cycle. At the edge where address N_WORDS−1 is retired, the block drops `o_rd_en` and enters DRAIN.
- Pipeline stage 1: a valid bit, delayed by one cycle, follows each issued address. This marks when RAM data is present.
- Pipeline stage 2: on the stage-1 valid, the block computes each lane j (bits 16j+15:16j) as (v_j ± k_j) mod 2^16. For q=2^15 it then clears bit 15 of each lane.
  - The result is registered into `o_c_mat`, with `o_c_mat_addr` equal to the stage-1 address and `o_c_mat_wen`=1.
  - Carries and borrows never cross lanes.
- DRAIN waits until the write of word N_WORDS−1 has been issued, then moves to DONE.
- DONE raises `o_done` for one cycle, then returns to IDLE.
- `i_start` is ignored outside IDLE, and the latched mode never changes mid-run.
- Reset values: `o_rd_en`=0, `o_rd_addr`=0, `o_c_mat`=0, `o_c_mat_addr`=0, `o_c_mat_wen`=0, `o_done`=0; state is IDLE and all pipeline valids are 0.
- Reset asserted mid-run: on the next edge every output takes its reset value and no further write occurs. A later `i_start` runs a full, clean pass.

## Timing

- E0 is the edge that samples `i_start`=1.
- `o_rd_addr`=a is presented after edge E(a), with `o_rd_en`=1, for a=0..15.
- Source data for address a is valid during the cycle after E(a+1).
- The result write for address a is visible after edge E(a+2), with `o_c_mat_wen`=1. Write addresses are contiguous and ascending, 0..15, one per cycle with no gaps.
- The last write is visible after E17. `o_done`=1 after E18, which is 18 cycles from start. The block is back in IDLE after E19 and accepts a new start there.
- Throughput is one word per cycle. Read latency of the source RAMs is fixed at 1 cycle.

## Test plan

- Level 1, add, all lanes v=0x7FFF and k=0x0001 → all 16 written words are 0x0000000000000000.
- Level 3, add, lane 0 v=0xFFFF k=0x0002 and lane 1 v=0x1234 k=0x0100, other lanes 0 → every word is 0x0000000013340001. Confirms no carry into lane 1.
- Level 1, sub, v=0x0000 k=0x0001 → every lane is 0x7FFF. Level 5 with the same data → every lane is 0xFFFF.
- Cycle count: start → `o_done` in exactly 18 cycles. Check that `o_c_mat_wen` is high on exactly 16 consecutive cycles with addresses 0..15, and that `o_done` is a single-cycle pulse.
- Pulse `i_start` again at cycle 5 of a run → ignored: there is still only one set of 16 writes and one `o_done`.
- Assert `i_rst` at cycle 8 of a run → on the next edge all outputs read 0 and no writes follow. A new run then produces correct results and `o_done` 18 cycles after its start.
